// File: rtl/node_injection_port.sv
// Host-side injection stage for a ring node: FIFO-buffered packet build and gapped CS strobes.
// Optional self-addressed request filter enabled by defining INJ_SELF_FILTER_EN.
module node_injection_port #(
    parameter logic [2:0]  NODE_IP    = 3'b000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned INJECT_GAP = 4,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          shiftInCLK,
    input  logic          resetN,
    input  logic          hostValid,
    output logic          hostReady,
    input  logic [2:0]    hostDest,
    input  logic [25:0]   hostPayload,
    output logic [31:0]   shiftOutData,
    output logic          shiftOutCS,
    output logic [CW-1:0] fifoCount,
    output logic          selfDrop
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e        state;
    logic [3:0]    gap_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   mem [FIFO_DEPTH];
    logic          accept;
    logic          push;
    logic          pop;
    logic          is_self;

    assign hostReady = resetN & (fifoCount != CW'(FIFO_DEPTH));
    assign accept    = hostValid & hostReady;

`ifdef INJ_SELF_FILTER_EN
    assign is_self = (hostDest == NODE_IP);

    always_ff @(posedge shiftInCLK or negedge resetN) begin
        if (!resetN) begin
            selfDrop <= 1'b0;
        end else begin
            selfDrop <= accept & is_self;
        end
    end
`else
    assign is_self  = 1'b0;
    assign selfDrop = 1'b0;
`endif

    assign push = accept & ~is_self;
    assign pop  = (state == StIdle) && (fifoCount != '0);

    // Packet storage needs no reset; validity is tracked by fifoCount.
    always_ff @(posedge shiftInCLK) begin
        if (push) begin
            mem[wr_ptr] <= {hostDest, NODE_IP, hostPayload};
        end
    end

    always_ff @(posedge shiftInCLK or negedge resetN) begin
        if (!resetN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + CW'(1);
            end else if (pop && !push) begin
                fifoCount <= fifoCount - CW'(1);
            end
        end
    end

    // GAP holds INJECT_GAP-1 cycles so that, with IDLE, strobes recur every INJECT_GAP+1.
    always_ff @(posedge shiftInCLK or negedge resetN) begin
        if (!resetN) begin
            state        <= StIdle;
            gap_cnt      <= '0;
            shiftOutData <= '0;
            shiftOutCS   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        shiftOutData <= mem[rd_ptr];
                        shiftOutCS   <= 1'b1;
                        state        <= StSend;
                    end
                end
                StSend: begin
                    shiftOutCS <= 1'b0;
                    if (INJECT_GAP <= 1) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= 4'(INJECT_GAP - 1);
                        state   <= StGap;
                    end
                end
                StGap: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt <= 4'd1) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_node_injection_port.sv
// Directed bench for node_injection_port: two instances (gap 4 / gap 1) with packet scoreboards.
module tb_node_injection_port;

    localparam logic [2:0] A_IP = 3'b100;
    localparam logic [2:0] B_IP = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready, a_cs, a_drop;
    logic [2:0]  a_dest, a_count;
    logic [25:0] a_pl;
    logic [31:0] a_data;
    logic        b_valid, b_ready, b_cs, b_drop;
    logic [2:0]  b_dest, b_count;
    logic [25:0] b_pl;
    logic [31:0] b_data;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          a_strobe_t[$];
    int          a_strobes = 0;
    int          b_strobes = 0;
    logic        a_cs_prev = 1'b0;
    logic        b_cs_prev = 1'b0;
    bit          a_saw_full = 1'b0;

    node_injection_port #(.NODE_IP(A_IP), .FIFO_DEPTH(4), .INJECT_GAP(4)) u_a (
        .shiftInCLK  (clk),
        .resetN      (rst_n),
        .hostValid   (a_valid),
        .hostReady   (a_ready),
        .hostDest    (a_dest),
        .hostPayload (a_pl),
        .shiftOutData(a_data),
        .shiftOutCS  (a_cs),
        .fifoCount   (a_count),
        .selfDrop    (a_drop)
    );

    node_injection_port #(.NODE_IP(B_IP), .FIFO_DEPTH(4), .INJECT_GAP(1)) u_b (
        .shiftInCLK  (clk),
        .resetN      (rst_n),
        .hostValid   (b_valid),
        .hostReady   (b_ready),
        .hostDest    (b_dest),
        .hostPayload (b_pl),
        .shiftOutData(b_data),
        .shiftOutCS  (b_cs),
        .fifoCount   (b_count),
        .selfDrop    (b_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // Scoreboard pops on every strobe; one-cycle width checked against the previous sample.
    always @(negedge clk) begin
        if (a_cs) begin
            a_strobes++;
            a_strobe_t.push_back(cyc);
            check("a_cs_one_cycle", 32'(a_cs_prev), 32'd0);
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL a_unexpected_strobe: observed %h expected none", a_data);
            end else begin
                check("a_packet", a_data, exp_a.pop_front());
            end
        end
        if (b_cs) begin
            b_strobes++;
            check("b_cs_one_cycle", 32'(b_cs_prev), 32'd0);
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL b_unexpected_strobe: observed %h expected none", b_data);
            end else begin
                check("b_packet", b_data, exp_b.pop_front());
            end
        end
        a_cs_prev = a_cs;
        b_cs_prev = b_cs;
    end

    // Leaves hostValid high on return (at accept edge + 1).
    task automatic req_a(input logic [2:0] dest, input logic [25:0] pl);
        bit done = 1'b0;
        a_valid = 1'b1;
        a_dest  = dest;
        a_pl    = pl;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (a_ready) begin
                exp_a.push_back({dest, A_IP, pl});
                done = 1'b1;
            end else begin
                if (!a_saw_full) check("a_full_count", 32'(a_count), 32'd4);
                a_saw_full = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail_now("a_req_timeout");
    endtask

    task automatic req_b(input logic [2:0] dest, input logic [25:0] pl);
        bit done = 1'b0;
        b_valid = 1'b1;
        b_dest  = dest;
        b_pl    = pl;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (b_ready) begin
`ifdef INJ_SELF_FILTER_EN
                if (dest != B_IP) exp_b.push_back({dest, B_IP, pl});
`else
                exp_b.push_back({dest, B_IP, pl});
`endif
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail_now("b_req_timeout");
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_a.size() != 0 || exp_b.size() != 0); i++) begin
            @(posedge clk);
        end
        repeat (10) @(posedge clk);
        #1;
        check("drain_a", 32'(exp_a.size()), 32'd0);
        check("drain_b", 32'(exp_b.size()), 32'd0);
    endtask

    initial begin
        int base;
        int c_exp[5];
        int s_exp[5];
        rst_n   = 1'b0;
        a_valid = 1'b0; a_dest = '0; a_pl = '0;
        b_valid = 1'b0; b_dest = '0; b_pl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_cs",    32'(a_cs),    32'd0);
        check("rst_a_data",  a_data,       32'd0);
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_a_drop",  32'(a_drop),  32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("a_ready_after_rst", 32'(a_ready), 32'd1);

        // Single request: one-cycle latency to strobe.
        req_a(3'b000, 26'h0924924);
        a_valid = 1'b0;
        check("t1_count_after_accept", 32'(a_count), 32'd1);
        check("t1_cs_not_yet",         32'(a_cs),    32'd0);
        @(posedge clk);
        #1;
        check("t1_cs_high", 32'(a_cs),    32'd1);
        check("t1_data",    a_data,       32'h10924924);
        check("t1_count0",  32'(a_count), 32'd0);
        @(posedge clk);
        #1;
        check("t1_cs_low",   32'(a_cs), 32'd0);
        check("t1_data_held", a_data,   32'h10924924);
        drain(20);

        // Six held requests into a 4-deep FIFO.
        a_strobe_t.delete();
        a_saw_full = 1'b0;
        for (int i = 1; i <= 6; i++) req_a(3'b001, 26'(i));
        a_valid = 1'b0;
        check("t2_ready_dropped", 32'(a_saw_full), 32'd1);
        drain(60);
        check("t2_strobes", 32'(a_strobe_t.size()), 32'd6);
        for (int i = 1; i < a_strobe_t.size(); i++) begin
            check("t2_spacing", 32'(a_strobe_t[i] - a_strobe_t[i-1]), 32'd5);
        end

        // Push coinciding with the IDLE pop at count 2.
        req_a(3'b011, 26'h0000AA);
        req_a(3'b011, 26'h0000BB);
        req_a(3'b011, 26'h0000CC);
        a_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_count_pre", 32'(a_count), 32'd2);
        req_a(3'b011, 26'h0000DD);
        a_valid = 1'b0;
        check("t6_count_same", 32'(a_count), 32'd2);
        check("t6_cs_pop",     32'(a_cs),    32'd1);
        drain(60);
        check("t6_count_end", 32'(a_count), 32'd0);

        // Reset during GAP with two entries queued.
        req_a(3'b000, 26'h0000111);
        req_a(3'b000, 26'h0000222);
        req_a(3'b000, 26'h0000333);
        a_valid = 1'b0;
        check("t4_count_queued", 32'(a_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_cs",    32'(a_cs),    32'd0);
        check("t4_data",  a_data,       32'd0);
        check("t4_count", 32'(a_count), 32'd0);
        check("t4_ready", 32'(a_ready), 32'd0);
        exp_a.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = a_strobes;
        repeat (20) @(posedge clk);
        #1;
        check("t4_no_strobe", 32'(a_strobes), 32'(base));
        check("t4_count_idle", 32'(a_count), 32'd0);

        // Gap of one: five pushes leave three buffered, then 1,0,1,0,1.
        for (int i = 0; i < 5; i++) req_b(3'b000, 26'(16 + i));
        b_valid = 1'b0;
        check("t3_count3", 32'(b_count), 32'd3);
        c_exp = '{2, 2, 1, 1, 0};
        s_exp = '{1, 0, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t3_cs",    32'(b_cs),    32'(s_exp[i]));
            check("t3_count", 32'(b_count), 32'(c_exp[i]));
        end
        drain(20);

        // Self-addressed request.
        base = b_strobes;
        req_b(B_IP, 26'h00ABCDE);
        b_valid = 1'b0;
`ifdef INJ_SELF_FILTER_EN
        check("t5_drop_pulse", 32'(b_drop),  32'd1);
        check("t5_count",      32'(b_count), 32'd0);
        @(posedge clk);
        #1;
        check("t5_drop_end", 32'(b_drop), 32'd0);
        check("t5_no_cs",    32'(b_cs),   32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_strobe", 32'(b_strobes), 32'(base));
`else
        check("t5_count", 32'(b_count), 32'd1);
        check("t5_drop",  32'(b_drop),  32'd0);
        @(posedge clk);
        #1;
        check("t5_cs",   32'(b_cs), 32'd1);
        check("t5_data", b_data,    32'h480ABCDE);
`endif
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
